// File: rtl/pcap_dma_pkg.sv
// ============================================================================
// pcap_dma_pkg : shared state encoding, IRQ flag indices and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package pcap_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_REQ       = 3'd2,
    ST_XFER      = 3'd3,
    ST_NEXT_BUF  = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  localparam int FLAG_BUF_DONE = 0;
  localparam int FLAG_COMPLETE = 1;
  localparam int FLAG_UNDERRUN = 2;
  localparam int FLAG_TIMEOUT  = 3;
  localparam int FLAG_OVERFLOW = 4;
  localparam int FLAG_AXI_ERR  = 5;

  localparam int DEF_BURST_LEN = 16;

  function automatic logic [23:0] sat24(input logic [31:0] v);
    return (v > 32'h00FF_FFFF) ? 24'hFF_FFFF : v[23:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcap_addr_fifo.sv
// ============================================================================
// pcap_addr_fifo : host buffer-address queue, show-ahead synchronous FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module pcap_addr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/pcap_dma_sched.sv
// ============================================================================
// pcap_dma_sched : carves host buffers into AXI bursts of PCAP capture data
// Optional idle timeout enabled by PCAP_DMA_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

import pcap_dma_pkg::*;

module pcap_dma_sched #(
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_AW    = 10,
  parameter int ADDR_DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pcap_armed_i,
  input  logic             pcap_done_i,
  input  logic [FIFO_AW:0] fifo_count_i,
  input  logic             addr_wstb_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      block_size_i,
  input  logic [31:0]      timeout_i,
  output logic             dma_req_o,
  output logic [31:0]      dma_addr_o,
  output logic [7:0]       dma_len_o,
  input  logic             dma_ack_i,
  input  logic             dma_done_i,
  input  logic             dma_err_i,
  output logic             irq_o,
  output logic [31:0]      irq_status_o,
  output logic             busy_o
);

  state_t      state, state_nxt;
  logic        armed_q, done_seen, tmo_close;
  logic [31:0] buf_words, base, offset, words_left, words_written;
  logic [7:0]  len_m1, pend_flags;
  logic        q_full, q_empty, pop, start_buf, load_len, irq_fire, tmo_hit;
  logic [31:0] q_head, sel_len, irq_count;
  logic [7:0]  irq_flags;

  wire         arm_rise  = pcap_armed_i && !armed_q;
  wire         ovf_now   = addr_wstb_i && q_full;
  wire  [31:0] fifo32    = 32'(fifo_count_i);
  wire  [31:0] cur_len   = 32'(len_m1) + 32'd1;
  wire  [31:0] burst_n   = (words_left < 32'(BURST_LEN)) ? words_left : 32'(BURST_LEN);
  wire  [7:0]  flags_all = irq_flags | pend_flags | (8'(ovf_now) << FLAG_OVERFLOW);

  pcap_addr_fifo #(.DEPTH(ADDR_DEPTH), .WIDTH(32)) u_addr_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (addr_wstb_i),
    .wr_data (addr_i),
    .pop     (pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

`ifdef PCAP_DMA_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) tmo_cnt <= '0;
    else if (state == ST_WAIT_DATA && state_nxt == ST_WAIT_DATA) tmo_cnt <= tmo_cnt + 32'd1;
    else tmo_cnt <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    start_buf = 1'b0;
    load_len  = 1'b0;
    sel_len   = 32'd1;
    irq_fire  = 1'b0;
    irq_flags = 8'h00;
    irq_count = 32'd0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_rise) begin
          if (q_empty) begin
            irq_fire                 = 1'b1;
            irq_flags[FLAG_UNDERRUN] = 1'b1;
          end else begin
            pop       = 1'b1;
            start_buf = 1'b1;
            state_nxt = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (fifo32 >= burst_n) begin
          sel_len = burst_n; load_len = 1'b1; state_nxt = ST_REQ;
        end else if (done_seen && fifo32 != 32'd0) begin
          sel_len = fifo32;  load_len = 1'b1; state_nxt = ST_REQ;
        end else if (done_seen) begin
          state_nxt = ST_FINISH;
        end
`ifdef PCAP_DMA_TIMEOUT_EN
        else if (timeout_i != 32'd0 && tmo_cnt + 32'd1 == timeout_i) begin
          if (fifo32 != 32'd0) begin
            sel_len = fifo32; load_len = 1'b1; state_nxt = ST_REQ;
          end else begin
            tmo_hit = 1'b1; state_nxt = ST_NEXT_BUF;
          end
        end
`endif
      end
      ST_REQ: begin
        if (dma_ack_i) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (dma_done_i) begin
          if (dma_err_i)                 state_nxt = ST_FINISH;
          else if (words_left == cur_len) state_nxt = ST_NEXT_BUF;
          else                            state_nxt = ST_WAIT_DATA;
        end
      end
      ST_NEXT_BUF: begin
        irq_fire  = 1'b1;
        irq_count = words_written;
        if (tmo_close) irq_flags[FLAG_TIMEOUT]  = 1'b1;
        else           irq_flags[FLAG_BUF_DONE] = 1'b1;
        if (q_empty) begin
          irq_flags[FLAG_UNDERRUN] = 1'b1;
          state_nxt                = ST_IDLE;
        end else begin
          pop       = 1'b1;
          start_buf = 1'b1;
          state_nxt = ST_WAIT_DATA;
        end
      end
      ST_FINISH: begin
        irq_fire                 = 1'b1;
        irq_flags[FLAG_COMPLETE] = 1'b1;
        irq_count                = words_written;
        state_nxt                = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      armed_q       <= 1'b0;
      done_seen     <= 1'b0;
      tmo_close     <= 1'b0;
      buf_words     <= '0;
      base          <= '0;
      offset        <= '0;
      words_left    <= '0;
      words_written <= '0;
      len_m1        <= '0;
      pend_flags    <= '0;
      irq_o         <= 1'b0;
      irq_status_o  <= '0;
    end else begin
      armed_q <= pcap_armed_i;
      // Disarm is folded into the sticky done so an in-flight burst still completes
      if (state == ST_IDLE || state == ST_FINISH) done_seen <= 1'b0;
      else if (pcap_done_i || !pcap_armed_i)      done_seen <= 1'b1;
      if (start_buf) begin
        base          <= q_head;
        offset        <= '0;
        words_written <= '0;
        if (state == ST_IDLE) begin
          buf_words  <= block_size_i >> 2;
          words_left <= block_size_i >> 2;
        end else begin
          words_left <= buf_words;
        end
      end
      if (load_len) len_m1 <= 8'(sel_len - 32'd1);
      if (state == ST_XFER && dma_done_i) begin
        offset        <= offset + (cur_len << 2);
        words_left    <= words_left - cur_len;
        words_written <= words_written + cur_len;
      end
      if (tmo_hit)                   tmo_close <= 1'b1;
      else if (state == ST_NEXT_BUF) tmo_close <= 1'b0;
      irq_o <= irq_fire;
      if (irq_fire) begin
        irq_status_o <= {sat24(irq_count), flags_all};
        pend_flags   <= '0;
      end else begin
        if (ovf_now) pend_flags[FLAG_OVERFLOW] <= 1'b1;
        if (state == ST_XFER && dma_done_i && dma_err_i) pend_flags[FLAG_AXI_ERR] <= 1'b1;
      end
    end
  end

  assign dma_req_o  = (state == ST_REQ);
  assign dma_addr_o = base + offset;
  assign dma_len_o  = len_m1;
  assign busy_o     = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pcap_dma_sched.sv
// ============================================================================
// tb_pcap_dma_sched : directed self-checking bench for pcap_dma_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pcap_dma_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcap_armed = 1'b0, pcap_done = 1'b0;
  logic [10:0] fifo_count = '0;
  logic        addr_wstb = 1'b0;
  logic [31:0] addr = '0, block_size = '0, timeout = '0;
  logic        dma_req, dma_ack = 1'b0, dma_done = 1'b0, dma_err = 1'b0;
  logic [31:0] dma_addr, irq_status;
  logic [7:0]  dma_len;
  logic        irq, busy;

  int checks = 0;
  int errors = 0;

  pcap_dma_sched #(.BURST_LEN(16), .FIFO_AW(10), .ADDR_DEPTH(16)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .pcap_armed_i (pcap_armed),
    .pcap_done_i  (pcap_done),
    .fifo_count_i (fifo_count),
    .addr_wstb_i  (addr_wstb),
    .addr_i       (addr),
    .block_size_i (block_size),
    .timeout_i    (timeout),
    .dma_req_o    (dma_req),
    .dma_addr_o   (dma_addr),
    .dma_len_o    (dma_len),
    .dma_ack_i    (dma_ack),
    .dma_done_i   (dma_done),
    .dma_err_i    (dma_err),
    .irq_o        (irq),
    .irq_status_o (irq_status),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    addr_wstb = 1'b1;
    addr      = a;
    tick();
    addr_wstb = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input logic [31:0] exp);
    int n = 0;
    while (irq !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_irq"}, 32'(irq), 32'd1);
    chk({tag, "_status"}, irq_status, exp);
    tick();
    chk({tag, "_pulse"}, 32'(irq), 32'd0);
  endtask

  // Models the AXI master side of the req/ack/done handshake
  task automatic burst(input string tag, input logic [31:0] exp_addr, input logic [7:0] exp_len,
                       input int ack_dly, input logic err, input logic drop_arm,
                       input logic [10:0] fifo_after);
    int n = 0;
    while (dma_req !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(dma_req), 32'd1);
    chk({tag, "_addr"}, dma_addr, exp_addr);
    chk({tag, "_len"}, 32'(dma_len), 32'(exp_len));
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      if (drop_arm && i == 4) pcap_armed = 1'b0;
      chk({tag, "_hold_req"}, 32'(dma_req), 32'd1);
      chk({tag, "_hold_addr"}, dma_addr, exp_addr);
      chk({tag, "_hold_len"}, 32'(dma_len), 32'(exp_len));
    end
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(dma_req), 32'd0);
    tick();
    dma_done   = 1'b1;
    dma_err    = err;
    fifo_count = fifo_after;
    tick();
    dma_done = 1'b0;
    dma_err  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_req", 32'(dma_req), 32'd0);
    chk("rst_addr", dma_addr, 32'd0);
    chk("rst_len", 32'(dma_len), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_status", irq_status, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Two 256-byte buffers, 64 words each: four full bursts fill the first
    push(32'h1000_0000);
    push(32'h1000_1000);
    block_size = 32'd256;
    fifo_count = 11'd64;
    pcap_armed = 1'b1;
    burst("t1_b0", 32'h1000_0000, 8'd15, 0, 1'b0, 1'b0, 11'd64);
    burst("t1_b1", 32'h1000_0040, 8'd15, 0, 1'b0, 1'b0, 11'd64);
    burst("t1_b2", 32'h1000_0080, 8'd15, 0, 1'b0, 1'b0, 11'd64);
    burst("t1_b3", 32'h1000_00C0, 8'd15, 0, 1'b0, 1'b0, 11'd0);
    wait_irq("t1_bufdone", 32'h0000_4001);
    repeat (3) begin
      tick();
      chk("t2_wait_noreq", 32'(dma_req), 32'd0);
    end
    chk("t2_busy", 32'(busy), 32'd1);
    fifo_count = 11'd7;
    repeat (3) begin
      tick();
      chk("t2_partial_noreq", 32'(dma_req), 32'd0);
    end

    // Capture done with 7 words left: one flush burst into the second buffer
    pcap_done = 1'b1;
    tick();
    pcap_done = 1'b0;
    burst("t2_flush", 32'h1000_1000, 8'd6, 0, 1'b0, 1'b0, 11'd0);
    wait_irq("t2_complete", 32'h0000_0702);
    chk("t2_idle", 32'(busy), 32'd0);
    pcap_armed = 1'b0;
    repeat (2) tick();

    // Arm with an empty address queue
    pcap_armed = 1'b1;
    wait_irq("t3_underrun", 32'h0000_0004);
    repeat (3) begin
      tick();
      chk("t3_noreq", 32'(dma_req), 32'd0);
    end
    chk("t3_idle", 32'(busy), 32'd0);
    pcap_armed = 1'b0;
    repeat (2) tick();

    // Delayed ack with disarm mid-request, then an error response (16 words counted)
    push(32'h2000_0000);
    fifo_count = 11'd64;
    pcap_armed = 1'b1;
    burst("t4_err", 32'h2000_0000, 8'd15, 10, 1'b1, 1'b1, 11'd64);
    wait_irq("t4_axierr", 32'h0000_1022);
    chk("t4_idle", 32'(busy), 32'd0);
    pcap_armed = 1'b0;
    fifo_count = 11'd0;
    repeat (2) tick();

    // Seventeen pushes into a 16-deep queue: overflow flagged, 16 buffers usable
    for (int i = 0; i < 17; i++) push(32'h3000_0000 + 32'(i) * 32'h100);
    pcap_armed = 1'b1;
    repeat (3) begin
      tick();
      chk("t5_noreq", 32'(dma_req), 32'd0);
    end
    pcap_armed = 1'b0;
    wait_irq("t5_ovf", 32'h0000_0012);
    for (int i = 0; i < 15; i++) begin
      pcap_armed = 1'b1;
      repeat (2) tick();
      pcap_armed = 1'b0;
      wait_irq("t5_drain", 32'h0000_0002);
    end
    pcap_armed = 1'b1;
    wait_irq("t5_empty", 32'h0000_0004);
    pcap_armed = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcap_dma_sched.md
Name: pcap_dma_sched

Overview:
Scheduler that moves position-capture (PCAP) sample words from the capture FIFO into host memory through the HP0 AXI write master.
- Host pre-loads a queue of buffer base addresses; the block carves each buffer into bursts and sequences the AXI master with a req/ack/done handshake.
- Closes buffers when full or when capture completes, and raises an interrupt carrying status flags and the closed buffer's sample count.
- Sits between the PCAP core and the AXI master in the carrier FPGA top.

Parameters:
BURST_LEN, 16, max 32-bit beats per AXI burst (power of 2, ≤256)
FIFO_AW, 10, capture FIFO address width; fifo_count_i is FIFO_AW+1 bits
ADDR_DEPTH, 16, depth of host buffer-address queue (power of 2)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
pcap_armed_i  in  1  capture armed (level)
pcap_done_i  in  1  capture completed, one-cycle pulse
fifo_count_i  in  FIFO_AW+1  words available in capture FIFO
addr_wstb_i  in  1  host write strobe, push buffer address
addr_i  in  32  buffer base address, 4-byte aligned (BURST_LEN*4 alignment preferred, not required)
block_size_i  in  32  buffer size in bytes, multiple of 4, ≥ 4*BURST_LEN; sampled at IDLE→WAIT_DATA
timeout_i  in  32  idle-cycle timeout (feature only)
dma_req_o  out  1  burst request
dma_addr_o  out  32  burst start address
dma_len_o  out  8  burst beats minus 1
dma_ack_i  in  1  master accepted request
dma_done_i  in  1  burst fully written (BRESP received)
dma_err_i  in  1  BRESP error, valid with dma_done_i
irq_o  out  1  one-cycle interrupt pulse
irq_status_o  out  32  [31:8] words in closed buffer, [7:0] flags
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; address queue emptied; word counters 0.
- Address queue: addr_wstb_i pushes addr_i; push when full drops the write and sets pending flag bit4 (OVERFLOW) for the next IRQ. Queue is not cleared on disarm, only on reset.
- IDLE: on rising edge of pcap_armed_i latch block_size_i, go WAIT_DATA. If queue empty at that point → raise IRQ flag bit2 (UNDERRUN), stay IDLE.
- WAIT_DATA: current buffer = head of queue (popped on entry to a new buffer), buf_words = block_size_i>>2, words_left = buf_words.
  n = min(BURST_LEN, words_left). If fifo_count_i ≥ n → REQ with len n.
  If pcap_done seen (sticky) and 0 < fifo_count_i < n → REQ with len fifo_count_i (flush).
  If pcap_done seen and fifo_count_i == 0 → FINISH.
- REQ: dma_req_o=1, dma_addr_o=base+offset, dma_len_o=len-1; held stable until dma_ack_i; then XFER. Exactly one cycle of req+ack overlap per burst.
- XFER: wait dma_done_i. Then offset+=4*len, words_left-=len. dma_err_i → flag bit5 (AXI_ERR), FINISH. words_left==0 → NEXT_BUF; else WAIT_DATA.
- NEXT_BUF: IRQ with bit0 (BUF_DONE), count=buf_words; pop next address; if queue empty → bit2 UNDERRUN also set, go IDLE (capture data left in FIFO is host's problem). Else WAIT_DATA.
- FINISH: IRQ with bit1 (COMPLETE), count=words written to current buffer (may be 0); go IDLE.
- pcap_done_i pulses in any state are latched sticky until FINISH; done while in IDLE is ignored.
- Disarm (pcap_armed_i falls) mid-transfer: treated as pcap_done (flush then FINISH); an in-flight burst always completes — never drop req before ack.
- IRQ: irq_o one cycle, irq_status_o updated same cycle and held until next IRQ. Flags from simultaneous events OR'd into one IRQ. Count saturates at 2^24-1.
- Offset arithmetic 32-bit wrap; no 4 KB boundary split (master's responsibility).

Optional Feature:
PCAP_DMA_TIMEOUT_EN: when defined, a counter in WAIT_DATA counts cycles with no eligible burst; on reaching timeout_i (≠0) issues a partial burst of fifo_count_i words if nonzero, else closes buffer with flag bit3 (TIMEOUT), count=words so far, and continues in next buffer. Undefined: timeout_i ignored, flag bit3 always 0.

Decomposition:
- Package pcap_dma_pkg: state encoding, IRQ flag bit indices (BUF_DONE=0, COMPLETE=1, UNDERRUN=2, TIMEOUT=3, OVERFLOW=4, AXI_ERR=5), BURST_LEN default.
- Sub-module pcap_addr_fifo: ADDR_DEPTH×32 synchronous FIFO with full/empty, same clk_i/reset_i.

Test Plan:
- Push 0x1000_0000, 0x1000_1000; block_size 256; arm; fifo_count 64 → 4 bursts len 15 at 0x1000_0000 +0x40 steps, IRQ status 0x0000_4001, next buffer base 0x1000_1000.
- fifo_count 7, pcap_done pulse → one burst dma_len_o=6, IRQ 0x0000_0702.
- Arm with empty queue → irq_o pulse, status flag 0x04, no dma_req_o.
- dma_ack_i delayed 10 cycles → dma_req_o/addr/len stable all 10 cycles; done with dma_err_i → flag 0x20, IDLE.
- Push ADDR_DEPTH+1 addresses → next IRQ has bit4 set; only 16 buffers consumed.
- (TIMEOUT_EN) timeout 100, fifo_count 3 static → burst len 3 after 100 cycles; then count 0 for 100 more → IRQ flag 0x08, count 3.
